asg_slew_lim: RTL and testbench
===============================

Name: asg_slew_lim

Overview:
- Output conditioner between the ASG channel's scaled/offset DAC word and the DAC interface.
- Limits the per-clock change of the DAC code to a programmable maximum step. Provides a soft mute that ramps to zero at the same rate, and a bypass mode.
- Counts limited samples for software diagnostics.
- One instance per ASG channel, in the dac_clk_i domain.

Parameters:
- DW, 14, DAC data width (two's complement).
- CW, 32, width of limited-sample counter.

Ports:
- dac_clk_i  in  1  DAC clock; sole clock.
- dac_rst_i  in  1  asynchronous, active-high reset.
- dat_i  in  DW  signed DAC code from ASG channel.
- set_en_i  in  1  1 = limiter active; 0 = bypass.
- set_step_i  in  DW  unsigned max |change| per clock; 0 = unlimited.
- set_mute_i  in  1  request soft mute (ramp to 0, hold).
- set_clr_i  in  1  synchronous clear of lim_cnt_o.
- dat_o  out  DW  signed conditioned DAC code, registered.
- limiting_o  out  1  registered; current dat_o was step-limited.
- muted_o  out  1  registered; output held at 0 by mute.
- lim_cnt_o  out  CW  number of limited samples, saturating.

Behaviour:
- Interface: one clock, dac_clk_i. Reset dac_rst_i is asynchronous and active-high.
- Reset values: dat_o=0, limiting_o=0, muted_o=0, lim_cnt_o=0, state=S_BYP.
- Latency: one register stage. Settings are sampled every cycle and take effect on the next dat_o update.
- Target t:
  - 0 if set_mute_i is high, else dat_i.
  - In S_BYP, t = set_mute_i ? 0 : dat_i, applied directly with no ramp.
- Arithmetic:
  - diff = t - dat_o, computed in DW+1 signed bits.
  - If set_step_i != 0 and |diff| > set_step_i: dat_o <= dat_o + sign(diff)*set_step_i, and limiting_o <= 1.
  - Otherwise dat_o <= t and limiting_o <= 0.
  - The output only moves toward t, so no overflow or saturation logic is needed. The full span -2^(DW-1)..2^(DW-1)-1 must be exact.
  - |diff| == set_step_i is not limited.
- States:
  - S_BYP: set_en_i=0. dat_o <= t each cycle; limiting_o=0. muted_o = (set_mute_i held). Exit to S_TRACK when set_en_i=1, continuing from the current dat_o with no jump.
  - S_TRACK: limiter follows dat_i. Go to S_RAMP when set_mute_i=1.
  - S_RAMP: limiter moves toward 0. When the next dat_o == 0, go to S_MUTED; muted_o asserts in the same cycle dat_o first shows 0. If set_mute_i=0, return to S_TRACK; the ramp back up to dat_i is rate-limited.
  - S_MUTED: dat_o=0, muted_o=1, limiting_o=0. If set_mute_i=0, go to S_TRACK and deassert muted_o.
  - From any state, set_en_i=0 goes to S_BYP (takes priority over mute transitions).
- Simultaneous events:
  - Enable and mute rising together: go to S_RAMP.
  - set_step_i changes mid-ramp: the new step is used from the next cycle.
  - set_step_i=0 in S_RAMP: reach 0 in one cycle.
- lim_cnt_o:
  - Increments by 1 each cycle limiting_o is loaded with 1.
  - Saturates at 2^CW-1.
  - set_clr_i has priority over increment.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronously). After release, the block starts in S_BYP.

Decomposition:
- Shared package asg_pkg:
  - enum asg_slew_state_t {S_BYP, S_TRACK, S_RAMP, S_MUTED}.
  - localparam ASG_DW = 14.
- No sub-module. The counter and the limiter datapath are inline, both small.

Test Plan:
- Reset: assert dac_rst_i asynchronously mid-ramp (dat_o=3000) -> dat_o=0, muted_o=0, lim_cnt_o=0 immediately; state S_BYP after release.
- Step limiting: en=1, step=1000, dat_o=0, dat_i steps to 5000 -> dat_o 1000, 2000, 3000, 4000, 5000 on successive clocks. limiting_o=1 for the first 4 updates and 0 on the 5th; lim_cnt_o=4.
- Soft mute: from dat_o=5000, step=2000, set_mute_i=1 -> dat_o 3000, 1000, 0; muted_o=1 in the cycle 0 appears. Release mute with dat_i=5000 -> 2000, 4000, 5000; muted_o=0.
- Full scale, unlimited: step=0, dat_o=8191, dat_i=-8192 -> dat_o=-8192 next clock, limiting_o=0. Step=16383 with the same stimulus gives the same result.
- Bypass: en=0, dat_i=-1234 -> dat_o=-1234 after 1 clock, no limiting. en 0->1 with dat_o=-1234, dat_i=0, step=500 -> -734, -234, 0.
- Counter: preload by forcing 2^CW-1 limited cycles (CW=4 in test build) -> saturates at 15. set_clr_i in the same cycle as a limited sample -> lim_cnt_o=0.

Source files
------------

// File: rtl/asg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : asg_pkg
//  Description : Shared types and constants for the ASG channel output path.
//  Revision    : 1.0  initial release
// ============================================================================
package asg_pkg;

    // DAC code width used by the ASG channel.
    localparam int ASG_DW = 14;

    // Slew limiter operating states.
    typedef enum logic [1:0] {
        S_BYP   = 2'd0,  // limiter disabled, output follows target directly
        S_TRACK = 2'd1,  // rate-limited tracking of the input code
        S_RAMP  = 2'd2,  // rate-limited ramp toward zero (soft mute)
        S_MUTED = 2'd3   // output held at zero by mute
    } asg_slew_state_t;

endpackage : asg_pkg
`default_nettype wire

// File: rtl/asg_slew_lim.sv
`default_nettype none
// ============================================================================
//  Module      : asg_slew_lim
//  Description : DAC output slew limiter with soft mute, bypass and a
//                saturating limited-sample counter. One register stage.
//  Revision    : 1.0  initial release
//
//  Ports
//    dac_clk_i   in   1   DAC clock, sole clock
//    dac_rst_i   in   1   asynchronous active-high reset
//    dat_i       in   DW  signed DAC code from the ASG channel
//    set_en_i    in   1   1 = limiter active, 0 = bypass
//    set_step_i  in   DW  unsigned max |change| per clock, 0 = unlimited
//    set_mute_i  in   1   soft mute request (ramp to zero and hold)
//    set_clr_i   in   1   synchronous clear of lim_cnt_o
//    dat_o       out  DW  conditioned signed DAC code (registered)
//    limiting_o  out  1   current dat_o was step-limited (registered)
//    muted_o     out  1   output held at zero by mute (registered)
//    lim_cnt_o   out  CW  saturating count of limited samples
// ============================================================================
module asg_slew_lim
    import asg_pkg::*;
#(
    parameter int DW = ASG_DW,
    parameter int CW = 32
) (
    input  logic                 dac_clk_i,
    input  logic                 dac_rst_i,
    input  logic signed [DW-1:0] dat_i,
    input  logic                 set_en_i,
    input  logic        [DW-1:0] set_step_i,
    input  logic                 set_mute_i,
    input  logic                 set_clr_i,
    output logic signed [DW-1:0] dat_o,
    output logic                 limiting_o,
    output logic                 muted_o,
    output logic        [CW-1:0] lim_cnt_o
);

    asg_slew_state_t        state_q, state_d;
    logic signed [DW-1:0]   dat_q, dat_d;
    logic                   lim_q, lim_d;
    logic                   muted_q, muted_d;
    logic        [CW-1:0]   cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // Limiter datapath. All arithmetic is one bit wider than the code so
    // that a full-scale swing (-2^(DW-1) .. 2^(DW-1)-1) is represented
    // exactly. The stepped result always lies between dat_q and the
    // target, so truncating back to DW bits never wraps.
    // ------------------------------------------------------------------
    logic signed [DW-1:0]   tgt;
    logic signed [DW:0]     tgt_x, dat_x, step_x, diff, stepped;
    logic        [DW:0]     mag;
    logic                   over;

    assign tgt     = set_mute_i ? '0 : dat_i;
    assign tgt_x   = {tgt[DW-1], tgt};
    assign dat_x   = {dat_q[DW-1], dat_q};
    assign step_x  = {1'b0, set_step_i};
    assign diff    = tgt_x - dat_x;
    // |diff| never reaches 2^DW, so negation cannot overflow here.
    assign mag     = diff[DW] ? (-diff) : diff;
    assign over    = (set_step_i != '0) && (mag > {1'b0, set_step_i});
    assign stepped = diff[DW] ? (dat_x - step_x) : (dat_x + step_x);

    always_comb begin
        dat_d = tgt;
        lim_d = 1'b0;
        if (set_en_i && over) begin
            dat_d = stepped[DW-1:0];
            lim_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State machine. The datapath already aims at zero whenever mute is
    // requested, so the state only decides how the mute status is
    // reported: S_RAMP while still moving, S_MUTED from the cycle the
    // output first shows zero. Disable overrides everything.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!set_en_i) begin
            state_d = S_BYP;
        end else begin
            case (state_q)
                S_BYP, S_TRACK, S_RAMP, S_MUTED: begin
                    if (!set_mute_i)
                        state_d = S_TRACK;
                    else if (dat_d == '0)
                        state_d = S_MUTED;
                    else
                        state_d = S_RAMP;
                end
                default: state_d = S_BYP;
            endcase
        end
    end

    // In bypass the mute target is applied in one step, so the flag
    // simply mirrors the request.
    assign muted_d = (state_d == S_MUTED) || ((state_d == S_BYP) && set_mute_i);

    // Saturating counter; clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (set_clr_i)
            cnt_d = '0;
        else if (lim_d && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state_q <= S_BYP;
            dat_q   <= '0;
            lim_q   <= 1'b0;
            muted_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            lim_q   <= lim_d;
            muted_q <= muted_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dat_o      = dat_q;
    assign limiting_o = lim_q;
    assign muted_o    = muted_q;
    assign lim_cnt_o  = cnt_q;

endmodule : asg_slew_lim
`default_nettype wire

// File: tb/tb_asg_slew_lim.sv
`default_nettype none
// ============================================================================
//  Module      : tb_asg_slew_lim
//  Description : Self-checking bench for asg_slew_lim (DW=14, CW=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_asg_slew_lim;
    import asg_pkg::*;

    localparam int DW = 14;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic                 dac_clk_i = 1'b0;
    logic                 dac_rst_i = 1'b1;
    logic signed [DW-1:0] dat_i = '0;
    logic                 set_en_i = 1'b0;
    logic        [DW-1:0] set_step_i = '0;
    logic                 set_mute_i = 1'b0;
    logic                 set_clr_i = 1'b0;
    logic signed [DW-1:0] dat_o;
    logic                 limiting_o;
    logic                 muted_o;
    logic        [CW-1:0] lim_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (plain integers).
    int m_out = 0;
    int m_lim = 0;
    int m_muted = 0;
    int m_cnt = 0;

    asg_slew_lim #(.DW(DW), .CW(CW)) dut (
        .dac_clk_i (dac_clk_i),
        .dac_rst_i (dac_rst_i),
        .dat_i     (dat_i),
        .set_en_i  (set_en_i),
        .set_step_i(set_step_i),
        .set_mute_i(set_mute_i),
        .set_clr_i (set_clr_i),
        .dat_o     (dat_o),
        .limiting_o(limiting_o),
        .muted_o   (muted_o),
        .lim_cnt_o (lim_cnt_o)
    );

    always #5 dac_clk_i = ~dac_clk_i;

    // Behavioural model: move toward the target by at most 'step', count
    // limited samples with saturation.
    function automatic void model_step();
        int t, d, a, s, lim;
        t   = set_mute_i ? 0 : int'(dat_i);
        s   = int'(set_step_i);
        d   = t - m_out;
        a   = (d < 0) ? -d : d;
        lim = 0;
        if (set_en_i && s != 0 && a > s) begin
            m_out = m_out + ((d > 0) ? s : -s);
            lim   = 1;
        end else begin
            m_out = t;
        end
        m_lim   = lim;
        m_muted = set_en_i ? int'(set_mute_i && m_out == 0) : int'(set_mute_i);
        if (set_clr_i)
            m_cnt = 0;
        else if (lim != 0 && m_cnt < CNT_MAX)
            m_cnt = m_cnt + 1;
    endfunction

    function automatic void model_reset();
        m_out = 0; m_lim = 0; m_muted = 0; m_cnt = 0;
    endfunction

    // Drive one clock of stimulus and advance the model; returns #1 after
    // the active edge so outputs can be sampled safely.
    task automatic apply(input bit en, input int step, input bit mute,
                         input bit clr, input int dat);
        set_en_i   = en;
        set_step_i = DW'(step);
        set_mute_i = mute;
        set_clr_i  = clr;
        dat_i      = DW'(dat);
        @(posedge dac_clk_i);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        // Initial reset state.
        n_vec++;
        if (int'(dat_o) !== 0 || limiting_o !== 1'b0 || muted_o !== 1'b0 || lim_cnt_o !== '0) begin
            n_err++;
            $display("FAIL reset_init: dat=%0d lim=%b mut=%b cnt=%0d, want all 0", dat_o, limiting_o, muted_o, lim_cnt_o);
        end
        // Ramp to 3000, then reset asynchronously between edges.
        for (int i = 0; i < 3; i++) apply(1, 1000, 0, 0, 5000);
        n_vec++;
        if (int'(dat_o) !== 3000) begin
            n_err++;
            $display("FAIL reset_pre: dat=%0d want 3000", dat_o);
        end
        #2 dac_rst_i = 1'b1;
        #1;
        n_vec++;
        if (int'(dat_o) !== 0 || limiting_o !== 1'b0 || muted_o !== 1'b0 || lim_cnt_o !== '0) begin
            n_err++;
            $display("FAIL reset_async: dat=%0d lim=%b mut=%b cnt=%0d, want all 0", dat_o, limiting_o, muted_o, lim_cnt_o);
        end
        model_reset();
        @(negedge dac_clk_i);
        dac_rst_i = 1'b0;
        #1;
        n_vec++;
        if (dut.state_q !== S_BYP) begin
            n_err++;
            $display("FAIL reset_state: state=%0d want %0d", dut.state_q, S_BYP);
        end
    endtask

    task automatic test_step_limit();
        int exp_d [5] = '{1000, 2000, 3000, 4000, 5000};
        bit exp_l [5] = '{1, 1, 1, 1, 0};
        apply(1, 1000, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            apply(1, 1000, 0, 0, 5000);
            n_vec++;
            if (int'(dat_o) !== exp_d[i] || limiting_o !== exp_l[i]) begin
                n_err++;
                $display("FAIL step_limit[%0d]: dat=%0d lim=%b want %0d %b", i, dat_o, limiting_o, exp_d[i], exp_l[i]);
            end
        end
        n_vec++;
        if (lim_cnt_o !== 4'd4) begin
            n_err++;
            $display("FAIL step_count: cnt=%0d want 4", lim_cnt_o);
        end
    endtask

    task automatic test_soft_mute();
        int exp_d [6] = '{3000, 1000, 0, 2000, 4000, 5000};
        bit exp_m [6] = '{0, 0, 1, 0, 0, 0};
        apply(1, 0, 0, 0, 5000);
        for (int i = 0; i < 6; i++) begin
            apply(1, 2000, (i < 3), 0, 5000);
            n_vec++;
            if (int'(dat_o) !== exp_d[i] || muted_o !== exp_m[i]) begin
                n_err++;
                $display("FAIL soft_mute[%0d]: dat=%0d mut=%b want %0d %b", i, dat_o, muted_o, exp_d[i], exp_m[i]);
            end
        end
    endtask

    task automatic test_full_scale();
        int steps [2] = '{0, 16383};
        for (int k = 0; k < 2; k++) begin
            apply(1, 0, 0, 0, 8191);
            apply(1, steps[k], 0, 0, -8192);
            n_vec++;
            if (int'(dat_o) !== -8192 || limiting_o !== 1'b0) begin
                n_err++;
                $display("FAIL full_scale step=%0d: dat=%0d lim=%b want -8192 0", steps[k], dat_o, limiting_o);
            end
        end
    endtask

    task automatic test_bypass();
        int exp_d [3] = '{-734, -234, 0};
        apply(0, 500, 0, 0, -1234);
        n_vec++;
        if (int'(dat_o) !== -1234 || limiting_o !== 1'b0) begin
            n_err++;
            $display("FAIL bypass: dat=%0d lim=%b want -1234 0", dat_o, limiting_o);
        end
        for (int i = 0; i < 3; i++) begin
            apply(1, 500, 0, 0, 0);
            n_vec++;
            if (int'(dat_o) !== exp_d[i]) begin
                n_err++;
                $display("FAIL bypass_exit[%0d]: dat=%0d want %0d", i, dat_o, exp_d[i]);
            end
        end
    endtask

    task automatic test_counter();
        apply(1, 1, 0, 1, 0);
        for (int i = 0; i < 20; i++) apply(1, 1, 0, 0, 5000);
        n_vec++;
        if (lim_cnt_o !== 4'(CNT_MAX)) begin
            n_err++;
            $display("FAIL cnt_sat: cnt=%0d want %0d", lim_cnt_o, CNT_MAX);
        end
        apply(1, 1, 0, 1, 5000);
        n_vec++;
        if (lim_cnt_o !== 4'd0 || limiting_o !== 1'b1) begin
            n_err++;
            $display("FAIL cnt_clr: cnt=%0d lim=%b want 0 1", lim_cnt_o, limiting_o);
        end
        apply(1, 1, 0, 0, 5000);
        n_vec++;
        if (lim_cnt_o !== 4'd1) begin
            n_err++;
            $display("FAIL cnt_inc: cnt=%0d want 1", lim_cnt_o);
        end
    endtask

    task automatic test_random();
        bit en = 1, mute = 0;
        int step = 100, dat = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 9) == 0) mute = ~mute;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       step = 0;
                    1:       step = int'($urandom_range(16383, 0));
                    default: step = int'($urandom_range(3000, 1));
                endcase
            end
            if ($urandom_range(0, 3) == 0) dat = int'($urandom_range(16383, 0)) - 8192;
            apply(en, step, mute, ($urandom_range(0, 19) == 0), dat);
            n_vec++;
            if (int'(dat_o) !== m_out || int'(limiting_o) !== m_lim ||
                int'(muted_o) !== m_muted || int'(lim_cnt_o) !== m_cnt) begin
                n_err++;
                $display("FAIL random[%0d]: dat=%0d lim=%b mut=%b cnt=%0d want %0d %0d %0d %0d",
                         i, dat_o, limiting_o, muted_o, lim_cnt_o, m_out, m_lim, m_muted, m_cnt);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge dac_clk_i);
        dac_rst_i = 1'b0;
        #1;
        test_reset();
        test_step_limit();
        test_soft_mute();
        test_full_scale();
        test_bypass();
        test_counter();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_asg_slew_lim
`default_nettype wire
